neuron_mac_accumulator: RTL and testbench

//  Upstream stage of the activation tag-check: one neuron's dot product plus bias.

---
 rtl/neuron_mac_accumulator_pkg.sv | 22 ++
 rtl/neuron_mac_accumulator_q_round_saturate.sv | 45 ++++
 rtl/neuron_mac_accumulator.sv | 169 ++++++++++++++++
 tb/tb_neuron_mac_accumulator.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/neuron_mac_accumulator_pkg.sv
// Shared definitions for the neuron MAC stage and the downstream activation stage:
// default Q-format geometry, saturation limits and the controller state encoding.
package neuron_mac_accumulator_pkg;

  localparam int DATAWIDTH_DEF  = 16;
  localparam int FRAC_BITS_DEF  = 11;
  localparam int MAX_INPUTS_DEF = 256;
  localparam int CNT_WIDTH_DEF  = 9;

  // Clip limits of the default Q5.11 result, shared with the activation stage
  localparam logic [15:0] SAT_MAX = 16'h7FFF;
  localparam logic [15:0] SAT_MIN = 16'h8000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACCUM = 3'd1,
    ST_DRAIN = 3'd2,
    ST_ROUND = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

endpackage

// File: rtl/neuron_mac_accumulator_q_round_saturate.sv
// Combinational reduction of the full-precision accumulator to a DATAWIDTH
// fixed-point value: round half up, then clip with a saturation flag.
module q_round_saturate
  import neuron_mac_accumulator_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int ACCWIDTH  = 2*DATAWIDTH_DEF + CNT_WIDTH_DEF + 1
) (
  input  logic [ACCWIDTH-1:0]  acc,
  output logic [DATAWIDTH-1:0] sum,
  output logic                 saturated
);

  localparam logic signed [ACCWIDTH-1:0] HALF_LSB =
    {{(ACCWIDTH-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
  localparam logic signed [ACCWIDTH-1:0] MAX_Q =
    {{(ACCWIDTH-DATAWIDTH+1){1'b0}}, {(DATAWIDTH-1){1'b1}}};
  localparam logic signed [ACCWIDTH-1:0] MIN_Q =
    {{(ACCWIDTH-DATAWIDTH+1){1'b1}}, {(DATAWIDTH-1){1'b0}}};

  logic signed [ACCWIDTH-1:0] biased_s;
  logic signed [ACCWIDTH-1:0] rounded_s;

  // Accumulator headroom guarantees the half-LSB bias cannot wrap
  assign biased_s  = $signed(acc) + HALF_LSB;
  assign rounded_s = biased_s >>> FRAC_BITS;

  // Clip the rounded value into the representable output range
  always_comb begin
    sum       = rounded_s[DATAWIDTH-1:0];
    saturated = 1'b0;
    if (rounded_s > MAX_Q) begin
      sum       = {1'b0, {(DATAWIDTH-1){1'b1}}};
      saturated = 1'b1;
    end else if (rounded_s < MIN_Q) begin
      sum       = {1'b1, {(DATAWIDTH-1){1'b0}}};
      saturated = 1'b1;
    end else begin
      sum       = rounded_s[DATAWIDTH-1:0];
      saturated = 1'b0;
    end
  end

endmodule

// File: rtl/neuron_mac_accumulator.sv
// One neuron's dot product plus bias: streams (input, weight) pairs, accumulates at
// full precision and hands a rounded, saturated sum to the activation stage.
module neuron_mac_accumulator
  import neuron_mac_accumulator_pkg::*;
#(
  parameter int DATAWIDTH  = DATAWIDTH_DEF,
  parameter int FRAC_BITS  = FRAC_BITS_DEF,
  parameter int MAX_INPUTS = MAX_INPUTS_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int ACCWIDTH   = 2*DATAWIDTH + CNT_WIDTH + 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_inputs,
  input  logic [DATAWIDTH-1:0] bias,
  input  logic                 activation_func,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic [DATAWIDTH-1:0] weight,
  output logic                 sum_valid,
  input  logic                 sum_ready,
  output logic [DATAWIDTH-1:0] sum,
  output logic                 act_func_out,
  output logic                 saturated
);

  localparam int                   PRODWIDTH = 2*DATAWIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(MAX_INPUTS);

  state_t                      state_r;
  logic [CNT_WIDTH-1:0]        num_r;
  logic [CNT_WIDTH-1:0]        count_r;
  logic signed [ACCWIDTH-1:0]  acc_r;
  logic signed [PRODWIDTH-1:0] prod_r;
  logic                        prod_v_r;
  logic                        in_ready_r;
  logic                        sum_valid_r;
  logic [DATAWIDTH-1:0]        sum_r;
  logic                        sat_r;
  logic                        act_r;

  logic [CNT_WIDTH-1:0]        num_clamped_s;
  logic                        handshake_s;
  logic                        last_beat_s;
  logic                        load_s;
  logic signed [PRODWIDTH-1:0] data_ext_s;
  logic signed [PRODWIDTH-1:0] weight_ext_s;
  logic signed [ACCWIDTH-1:0]  bias_ext_s;
  logic signed [ACCWIDTH-1:0]  prod_ext_s;
  logic [DATAWIDTH-1:0]        rnd_sum_s;
  logic                        rnd_sat_s;

  assign handshake_s  = (state_r == ST_ACCUM) && in_valid && in_ready_r;
  assign last_beat_s  = (count_r == (num_r - CNT_ONE));
  assign load_s       = (state_r == ST_IDLE) && start;
  assign data_ext_s   = {{DATAWIDTH{in_data[DATAWIDTH-1]}}, in_data};
  assign weight_ext_s = {{DATAWIDTH{weight[DATAWIDTH-1]}}, weight};
  assign bias_ext_s   = {{(ACCWIDTH-DATAWIDTH){bias[DATAWIDTH-1]}}, bias};
  assign prod_ext_s   = {{(ACCWIDTH-PRODWIDTH){prod_r[PRODWIDTH-1]}}, prod_r};

  // Over-long requests are clamped so the count can never run past the design limit
  always_comb begin
    num_clamped_s = num_inputs;
    if (num_inputs > CNT_MAX) begin
      num_clamped_s = CNT_MAX;
    end else begin
      num_clamped_s = num_inputs;
    end
  end

  q_round_saturate #(
    .DATAWIDTH (DATAWIDTH),
    .FRAC_BITS (FRAC_BITS),
    .ACCWIDTH  (ACCWIDTH)
  ) u_round (
    .acc       (acc_r),
    .sum       (rnd_sum_s),
    .saturated (rnd_sat_s)
  );

  // Product register and accumulator; the add trails the handshake by one cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prod_r   <= {PRODWIDTH{1'b0}};
      prod_v_r <= 1'b0;
      acc_r    <= {ACCWIDTH{1'b0}};
    end else begin
      prod_v_r <= handshake_s;
      if (handshake_s) begin
        prod_r <= data_ext_s * weight_ext_s;
      end
      if (load_s) begin
        acc_r <= bias_ext_s <<< FRAC_BITS;
      end else if (prod_v_r) begin
        acc_r <= acc_r + prod_ext_s;
      end
    end
  end

  // Sequencing FSM with all handshake and result outputs registered
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      num_r       <= CNT_ZERO;
      count_r     <= CNT_ZERO;
      in_ready_r  <= 1'b0;
      sum_valid_r <= 1'b0;
      sum_r       <= {DATAWIDTH{1'b0}};
      sat_r       <= 1'b0;
      act_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            num_r   <= num_clamped_s;
            act_r   <= activation_func;
            count_r <= CNT_ZERO;
            if (num_clamped_s == CNT_ZERO) begin
              state_r <= ST_DRAIN;
            end else begin
              state_r    <= ST_ACCUM;
              in_ready_r <= 1'b1;
            end
          end
        end
        ST_ACCUM: begin
          if (handshake_s) begin
            count_r <= count_r + CNT_ONE;
            if (last_beat_s) begin
              state_r    <= ST_DRAIN;
              in_ready_r <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          state_r <= ST_ROUND;
        end
        ST_ROUND: begin
          sum_r       <= rnd_sum_s;
          sat_r       <= rnd_sat_s;
          sum_valid_r <= 1'b1;
          state_r     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (sum_ready) begin
            sum_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b0;
          sum_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_r;
  assign sum_valid    = sum_valid_r;
  assign sum          = sum_r;
  assign saturated    = sat_r;
  assign act_func_out = act_r;

endmodule

// File: tb/tb_neuron_mac_accumulator.sv
// Directed, table-driven bench for neuron_mac_accumulator with hand-computed Q5.11 results.
module tb_neuron_mac_accumulator;

  typedef struct packed {
    logic [8:0]        n;
    logic [15:0]       bias;
    logic              act;
    logic [3:0][15:0]  d;
    logic [3:0][15:0]  w;
    logic [15:0]       exp_sum;
    logic              exp_sat;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  num_inputs = 9'd0;
  logic [15:0] bias = 16'h0000;
  logic        activation_func = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0000;
  logic [15:0] weight = 16'h0000;
  logic        sum_valid;
  logic        sum_ready = 1'b0;
  logic [15:0] sum;
  logic        act_func_out;
  logic        saturated;

  int checks = 0;
  int errors = 0;
  vec_t vecs [11];

  always #5 clock = ~clock;

  neuron_mac_accumulator dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .num_inputs      (num_inputs),
    .bias            (bias),
    .activation_func (activation_func),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .weight          (weight),
    .sum_valid       (sum_valid),
    .sum_ready       (sum_ready),
    .sum             (sum),
    .act_func_out    (act_func_out),
    .saturated       (saturated)
  );

  task automatic chk(input string nm, input logic [15:0] actual, input logic [15:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, actual, required);
    end
  endtask

  function automatic vec_t mk(input logic [8:0] n, input logic [15:0] b, input logic a,
                              input logic [63:0] d, input logic [63:0] w,
                              input logic [15:0] es, input logic esat);
    vec_t v;
    v.n = n; v.bias = b; v.act = a; v.d = d; v.w = w;
    v.exp_sum = es; v.exp_sat = esat;
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs one neuron from IDLE through the sum handshake, checking latency and result
  task automatic run_vec(input vec_t v, input string nm);
    int g;
    int cyc;
    logic saw_ready;
    start = 1'b1; num_inputs = v.n; bias = v.bias; activation_func = v.act;
    tick();
    start = 1'b0;
    saw_ready = 1'b0;
    for (int i = 0; i < int'(v.n); i++) begin
      in_valid = 1'b1; in_data = v.d[i]; weight = v.w[i];
      if (i == 0) chk({nm, ".ready_1cyc"}, 16'(in_ready), 16'd1);
      g = 0;
      while (!in_ready && g < 10) begin tick(); g++; end
      tick();
    end
    in_valid = 1'b0;
    cyc = 0;
    while (!sum_valid && cyc < 20) begin
      if (in_ready) saw_ready = 1'b1;
      tick();
      cyc++;
    end
    chk({nm, ".latency"}, 16'(cyc), 16'd2);
    chk({nm, ".ready_after"}, 16'(saw_ready | in_ready), 16'd0);
    chk({nm, ".sum"}, sum, v.exp_sum);
    chk({nm, ".sat"}, 16'(saturated), 16'(v.exp_sat));
    chk({nm, ".act"}, 16'(act_func_out), 16'(v.act));
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    chk({nm, ".valid_drop"}, 16'(sum_valid), 16'd0);
  endtask

  initial begin
    int cyc;
    vecs[0]  = mk(9'd2, 16'h0400, 1'b0, {16'h0, 16'h0, 16'h1000, 16'h0800},
                  {16'h0, 16'h0, 16'h0200, 16'h0400}, 16'h0C00, 1'b0);
    vecs[1]  = mk(9'd4, 16'h0000, 1'b0, {4{16'h3800}}, {4{16'h1000}}, 16'h7FFF, 1'b1);
    vecs[2]  = mk(9'd4, 16'h0000, 1'b1, {4{16'h3800}}, {4{16'hF000}}, 16'h8000, 1'b1);
    vecs[3]  = mk(9'd1, 16'h0000, 1'b0, {48'h0, 16'h0001}, {48'h0, 16'h0400}, 16'h0001, 1'b0);
    vecs[4]  = mk(9'd1, 16'h0000, 1'b0, {48'h0, 16'hFFFF}, {48'h0, 16'h0400}, 16'h0000, 1'b0);
    vecs[5]  = mk(9'd0, 16'hFC00, 1'b1, 64'h0, 64'h0, 16'hFC00, 1'b0);
    vecs[6]  = mk(9'd0, 16'h7FFF, 1'b0, 64'h0, 64'h0, 16'h7FFF, 1'b0);
    vecs[7]  = mk(9'd0, 16'h8000, 1'b1, 64'h0, 64'h0, 16'h8000, 1'b0);
    vecs[8]  = mk(9'd1, 16'h0000, 1'b0, {48'h0, 16'hFFFF}, {48'h0, 16'h0C00}, 16'hFFFF, 1'b0);
    vecs[9]  = mk(9'd3, 16'h0100, 1'b1, {16'h0, {3{16'h0C00}}}, {16'h0, {3{16'hF800}}},
                  16'hDD00, 1'b0);
    vecs[10] = mk(9'd1, 16'h0000, 1'b0, {48'h0, 16'h7FFF}, {48'h0, 16'h0800}, 16'h7FFF, 1'b0);

    // reset state
    tick(); tick();
    chk("rst.in_ready", 16'(in_ready), 16'd0);
    chk("rst.sum_valid", 16'(sum_valid), 16'd0);
    chk("rst.sum", sum, 16'h0000);
    chk("rst.sat", 16'(saturated), 16'd0);
    chk("rst.act", 16'(act_func_out), 16'd0);
    reset_n = 1'b1;
    tick();

    for (int k = 0; k < 11; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // n=3 with in_valid gaps, then a long backpressured hold
    start = 1'b1; num_inputs = 9'd3; bias = 16'h0000; activation_func = 1'b0;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 16'h0800; weight = 16'h0800;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("gap.ready_held", 16'(in_ready), 16'd1);
    chk("gap.no_valid", 16'(sum_valid), 16'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (!sum_valid && cyc < 20) begin tick(); cyc++; end
    chk("gap.latency", 16'(cyc), 16'd2);
    start = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("hold.sum", sum, 16'h1800);
      chk("hold.valid", 16'(sum_valid), 16'd1);
      chk("hold.ready", 16'(in_ready), 16'd0);
      tick();
    end
    chk("hold.sat", 16'(saturated), 16'd0);
    start = 1'b0; in_valid = 1'b0; sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    chk("hold.valid_drop", 16'(sum_valid), 16'd0);
    tick();
    chk("hold.start_ignored", 16'(in_ready), 16'd0);

    // reset in ACCUM after one accepted pair
    start = 1'b1; num_inputs = 9'd3; bias = 16'h0400; activation_func = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 16'h0800; weight = 16'h0800;
    tick();
    reset_n = 1'b0;
    #1;
    chk("mid_rst.in_ready", 16'(in_ready), 16'd0);
    chk("mid_rst.sum_valid", 16'(sum_valid), 16'd0);
    chk("mid_rst.sum", sum, 16'h0000);
    chk("mid_rst.sat", 16'(saturated), 16'd0);
    chk("mid_rst.act", 16'(act_func_out), 16'd0);
    in_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mid_rst.no_sum", 16'(sum_valid | in_ready), 16'd0);
    end
    run_vec(vecs[0], "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
